// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// active-low segment patterns and parameter legality limits.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segments a..g on bits 6..0, active-low; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0001100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    localparam int NDIG_MIN = 1;
    localparam int NDIG_MAX = 8;
    localparam int DIV_MIN  = 2;
    localparam int DIV_MAX  = 1 << 20;

    function automatic bit params_legal(input int ndig, input int div, input int guard);
        return (ndig >= NDIG_MIN) && (ndig <= NDIG_MAX) &&
               (div >= DIV_MIN) && (div <= DIV_MAX) &&
               (guard >= 0) && (guard <= div - 1);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder with a blank override.
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, frame-synchronous
// double-buffered display data, anode guard time and leading-zero blanking.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int GUARD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp,
    input  logic              blank_lz,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp_n,
    output logic              pending,
    output logic              frame_done
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(DIV);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NDIG - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

    if (!params_legal(NDIG, DIV, GUARD)) begin : g_param_check
        $error("seg7_scan_driver: illegal NDIG/DIV/GUARD combination");
    end

    logic [CW-1:0]     cnt, cnt_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [4*NDIG-1:0] pend_value, disp_value, disp_value_nx;
    logic [NDIG-1:0]   pend_dp, disp_dp, disp_dp_nx;
    logic              pend_blz, disp_blz, disp_blz_nx;
    logic              tick, frame_end, apply;
    logic [NDIG-1:0]   zero_from;
    logic              zero_acc;
    logic [3:0]        nibble;
    logic              lz_blank;
    logic [6:0]        dec_seg;
    logic [NDIG-1:0]   an_sel, an_nx;
    logic [6:0]        seg_nx;
    logic              dp_n_nx;

    assign tick      = en && (cnt == LAST_CNT);
    assign frame_end = tick && (idx == LAST_IDX);
    // Only data that was already pending before the boundary cycle is applied.
    assign apply     = frame_end && pending;

    always_comb begin
        cnt_nx = cnt;
        idx_nx = idx;
        if (en) begin
            cnt_nx = (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
        end
        if (tick) begin
            idx_nx = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
    end

    assign disp_value_nx = apply ? pend_value : disp_value;
    assign disp_dp_nx    = apply ? pend_dp    : disp_dp;
    assign disp_blz_nx   = apply ? pend_blz   : disp_blz;

    // zero_from[i] is set when digit i and every digit above it are zero.
    always_comb begin
        zero_acc  = 1'b1;
        zero_from = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_acc     = zero_acc && (disp_value_nx[4*i +: 4] == 4'd0);
            zero_from[i] = zero_acc;
        end
    end

    // Outputs are built from next-cycle state so they line up with the new index.
    assign nibble   = disp_value_nx[{idx_nx, 2'b00} +: 4];
    assign lz_blank = disp_blz_nx && (idx_nx != '0) && zero_from[idx_nx];

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .blank  (lz_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        an_sel = '1;
        for (int i = 0; i < NDIG; i++) begin
            an_sel[i] = (idx_nx != IW'(i));
        end
    end

    assign an_nx   = (!en || (cnt_nx < GUARD_CNT)) ? '1 : an_sel;
    assign seg_nx  = en ? dec_seg : SEG_BLANK;
    assign dp_n_nx = en ? ~disp_dp_nx[idx_nx] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blz   <= 1'b0;
            pending    <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blz   <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            disp_value <= disp_value_nx;
            disp_dp    <= disp_dp_nx;
            disp_blz   <= disp_blz_nx;
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_blz   <= blank_lz;
            end
            // A load in the apply cycle keeps pending set for the next frame.
            pending    <= load ? 1'b1 : (apply ? 1'b0 : pending);
            an         <= an_nx;
            seg        <= seg_nx;
            dp_n       <= dp_n_nx;
            frame_done <= frame_end;
        end
    end

endmodule
